// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between two byte requesters; ack 1 cycle after grant, pload at +2, enable at +3.
// Requests are held off while busy (no queueing); a watchdog abandons frames whose done flag never rises.
module uart_tx_scheduler #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [7:0] tx_data,
    output logic       tx_pload,
    output logic       tx_enable,
    input  logic       tx_done,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [19:0] WD_LAST  = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_served_q, last_served_d;
    logic        done_prev_q, done_prev_d;
    logic [19:0] wd_cnt_q, wd_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_pload_q, tx_pload_d;
    logic        tx_enable_q, tx_enable_d;
    logic        busy_q, busy_d;
    logic        grant_id_q, grant_id_d;
    logic        timeout_err_q, timeout_err_d;

    logic        grant_vld;
    logic        grant_sel;
    logic        done_edge;

    // With both pending, the requester not served last wins.
    assign grant_vld = req0 | req1;
    assign grant_sel = (req0 & req1) ? ~last_served_q : req1;
    assign done_edge = tx_done & ~done_prev_q;

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        done_prev_d   = tx_done;
        wd_cnt_d      = wd_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        tx_data_d     = tx_data_q;
        tx_pload_d    = 1'b0;
        tx_enable_d   = 1'b0;
        grant_id_d    = grant_id_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d       = SETUP;
                    grant_id_d    = grant_sel;
                    last_served_d = grant_sel;
                    tx_data_d     = grant_sel ? data1 : data0;
                    ack0_d        = ~grant_sel;
                    ack1_d        = grant_sel;
                end
            end
            SETUP: begin
                state_d    = LOAD;
                tx_pload_d = 1'b1;
            end
            LOAD: begin
                state_d     = SEND;
                tx_enable_d = 1'b1;
                wd_cnt_d    = 20'd0;
            end
            SEND: begin
                // A done edge on the final watchdog cycle still counts as success.
                if (done_edge) begin
                    state_d   = GAP;
                    gap_cnt_d = 16'd0;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d       = GAP;
                    gap_cnt_d     = 16'd0;
                    timeout_err_d = 1'b1;
                end else begin
                    tx_enable_d = 1'b1;
                    wd_cnt_d    = wd_cnt_q + 20'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            done_prev_q   <= 1'b0;
            wd_cnt_q      <= 20'd0;
            gap_cnt_q     <= 16'd0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_pload_q    <= 1'b0;
            tx_enable_q   <= 1'b0;
            busy_q        <= 1'b0;
            grant_id_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            done_prev_q   <= done_prev_d;
            wd_cnt_q      <= wd_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            tx_data_q     <= tx_data_d;
            tx_pload_q    <= tx_pload_d;
            tx_enable_q   <= tx_enable_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign tx_data     = tx_data_q;
    assign tx_pload    = tx_pload_q;
    assign tx_enable   = tx_enable_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences the UART transmitter (shift register, bit counter, clock16 path) and shares it between two byte requesters.
- Round-robin arbitration between the requesters.
- Presents the granted byte, pulses the transmitter's parallel load, holds its enable until the character-done flag rises, then enforces an inter-frame idle gap.
- Includes a watchdog so that a missing done flag cannot hang the link.

Parameters:
- GAP_CYCLES, 16: CLOCK_50 cycles of enforced idle after each frame; legal range 1..65535.
- TIMEOUT_CYCLES, 1000000: CLOCK_50 cycles in SEND without a done edge before the frame is abandoned; must be less than 2^20.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 has a byte pending; held until ack0.
- data0  in  8  requester 0 byte; stable while req0 is high.
- ack0  out  1  one-cycle pulse: byte 0 accepted.
- req1  in  1  requester 1 byte pending.
- data1  in  8  requester 1 byte.
- ack1  out  1  one-cycle pulse: byte 1 accepted.
- tx_data  out  8  byte to the transmitter parallel-load input.
- tx_pload  out  1  transmitter parallel-load strobe.
- tx_enable  out  1  transmitter enable.
- tx_done  in  1  transmitter character-done flag (charTX).
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  1  requester currently or most recently served.
- timeout_err  out  1  sticky: a frame was abandoned by the watchdog.

Behaviour:
- All outputs are registered.
- Reset values: ack0=0, ack1=0, tx_data=8'h00, tx_pload=0, tx_enable=0, busy=0, grant_id=0, timeout_err=0, state=IDLE, last_served=1 (so requester 0 wins first), done_prev=0, all counters=0.
- Reset mid-frame has the same effect as a power-on reset: transmitter enable drops on the next edge and timeout_err clears.
- States: IDLE -> SETUP -> LOAD -> SEND -> GAP -> IDLE.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the requester that is not last_served.
  - On the granting edge: latch the byte into tx_data, set grant_id and last_served, pulse the matching ack, go to SETUP.
- SETUP, one cycle: ack high, tx_data stable, tx_pload=0. This gives data a full cycle of setup ahead of the asynchronous load.
- LOAD, one cycle: tx_pload=1, ack=0.
- SEND:
  - tx_pload=0, tx_enable=1, tx_data held.
  - done_edge = tx_done & ~done_prev; done_prev samples tx_done every cycle in every state.
  - On done_edge: tx_enable=0, go to GAP.
  - The watchdog counter increments every SEND cycle. When it reaches TIMEOUT_CYCLES-1 without done_edge: set timeout_err, tx_enable=0, go to GAP.
  - If done_edge and timeout coincide, done wins and timeout_err is not set.
- GAP: tx_enable=0. Count GAP_CYCLES cycles, then go to IDLE. Both counters clear on entry to their state.
- Latency: req sampled high at IDLE edge k gives ack at k+1, tx_pload at k+2, tx_enable at k+3.
- After a done edge, the earliest next ack is GAP_CYCLES+1 edges later.
- A done edge outside SEND is ignored. If tx_done is already high on SEND entry, the scheduler waits for it to fall and rise again.
- Requesters must drop req, or present a new byte, on the cycle after ack. A req still high in IDLE is a new request.
- Requests arriving while busy are held off; there is no queueing beyond the req level.
- busy = (state != IDLE).

Test Plan:
- Reset, then req0=1, data0=8'hA5: ack0 high exactly 1 cycle after the sampling edge; tx_data=A5; tx_pload 1 cycle later for 1 cycle; tx_enable the next cycle. Model pulses tx_done 40 cycles later -> tx_enable low next edge; busy low after GAP_CYCLES=16 more cycles.
- req0 and req1 both held high, data 8'h11/8'h22, 4 frames: grant order 0,1,0,1; ack0 and ack1 never high together; tx_data sequence 11,22,11,22.
- tx_done held high before SEND entry: no completion until tx_done falls and rises again; then GAP.
- TIMEOUT_CYCLES=50, tx_done never asserted: tx_enable drops after 50 SEND cycles, timeout_err=1 and stays 1 through later good frames until reset.
- reset asserted in SEND and in GAP: on the next edge all outputs return to reset values; the next grant with both requesters pending goes to requester 0.
- Done edge on exactly cycle TIMEOUT_CYCLES-1 of SEND: timeout_err stays 0; tx_done pulse during GAP/IDLE has no effect on state.
